// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register: main entry drives outputs, skid catches one overflow; latency 1.
// Backpressure: in_ready is registered (skid empty), never combinational on out_ready; flush drops held entries.
module pipe_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 9,
  parameter int ZERO_CTRL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_Data,
  input  logic [CTRL_W-1:0] in_Ctrl,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_Data,
  output logic [CTRL_W-1:0] out_Ctrl,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  logic              mainValid;
  logic              skidValid;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic              inReadyQ;
  logic [1:0]        occQ;

  logic accept;
  logic drain;
  logic moveSkid;
  logic loadMain;
  logic loadSkid;
  logic mainValidNxt;
  logic skidValidNxt;

  always_comb begin
    accept   = in_valid & inReadyQ;
    drain    = mainValid & out_ready;
    moveSkid = drain & skidValid & ~flush;
    // inReadyQ already implies an empty skid, so an accept lands in main or skid.
    loadMain = accept & (~mainValid | drain) & ~flush;
    loadSkid = accept & mainValid & ~drain & ~flush;

    mainValidNxt = moveSkid | loadMain | (mainValid & ~drain);
    skidValidNxt = loadSkid | (skidValid & ~drain);
    if (flush) begin
      mainValidNxt = 1'b0;
      skidValidNxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      mainData  <= '0;
      mainCtrl  <= '0;
      skidData  <= '0;
      skidCtrl  <= '0;
      inReadyQ  <= 1'b1;
      occQ      <= 2'd0;
    end else begin
      mainValid <= mainValidNxt;
      skidValid <= skidValidNxt;
      inReadyQ  <= ~skidValidNxt;
      occQ      <= {1'b0, mainValidNxt} + {1'b0, skidValidNxt};
      if (moveSkid) begin
        mainData <= skidData;
        mainCtrl <= skidCtrl;
      end else if (loadMain) begin
        mainData <= in_Data;
        mainCtrl <= in_Ctrl;
      end
      if (loadSkid) begin
        skidData <= in_Data;
        skidCtrl <= in_Ctrl;
      end
    end
  end

  assign in_ready  = inReadyQ;
  assign out_valid = mainValid;
  assign out_Data  = mainData;
  assign out_Ctrl  = ((ZERO_CTRL != 0) && !mainValid) ? '0 : mainCtrl;
  assign occupancy = occQ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: scoreboard of accepted entries checked by a negedge monitor,
// plus directed vectors and a second instance built without control zeroing.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_Data, out_Data;
  logic [CW-1:0] in_Ctrl, out_Ctrl;
  logic [1:0]    occupancy;

  logic          zReset, zFlush, zInValid, zInReady, zOutValid, zOutReady;
  logic [DW-1:0] zInData, zOutData;
  logic [CW-1:0] zInCtrl, zOutCtrl;
  logic [1:0]    zOcc;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_Data(in_Data), .in_Ctrl(in_Ctrl), .in_ready(in_ready),
    .out_valid(out_valid), .out_Data(out_Data), .out_Ctrl(out_Ctrl),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL(0)) dutNoZero (
    .clk(clk), .reset(zReset), .flush(zFlush),
    .in_valid(zInValid), .in_Data(zInData), .in_Ctrl(zInCtrl), .in_ready(zInReady),
    .out_valid(zOutValid), .out_Data(zOutData), .out_Ctrl(zOutCtrl),
    .out_ready(zOutReady), .occupancy(zOcc)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic monOn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard bookkeeping: what the stage holds after each edge.
  always @(posedge clk) begin
    if (reset || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back('{d: in_Data, c: in_Ctrl});
  end

  always @(negedge clk) begin
    ent_t e;
    if (monOn) begin
      check("occ_vs_model", 64'(occupancy), 64'(sb.size()));
      check("valid_vs_model", 64'(out_valid), 64'(sb.size() != 0));
      check("in_ready_vs_occ", 64'(in_ready), 64'(occupancy != 2'd2));
      if (!out_valid) check("ctrl_bubble_zero", 64'(out_Ctrl), 64'(0));
      if (out_valid && out_ready && !reset) begin
        if (sb.size() == 0) check("unexpected_output", 64'(out_valid), 64'(0));
        else begin
          e = sb.pop_front();
          check("out_data_order", 64'(out_Data), 64'(e.d));
          check("out_ctrl_order", 64'(out_Ctrl), 64'(e.c));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_Data = '0; in_Ctrl = '0; out_ready = 1'b0;
    zReset = 1'b1; zFlush = 1'b0; zInValid = 1'b0; zInData = '0; zInCtrl = '0; zOutReady = 1'b0;
    repeat (3) cyc();
    in_valid = 1'b1; in_Data = 32'hDEAD; out_ready = 1'b1;  // reset must still dominate
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_data", 64'(out_Data), 64'(0));
    check("rst_out_ctrl", 64'(out_Ctrl), 64'(0));
    cyc();
    check("rst_hold_valid", 64'(out_valid), 64'(0));
    monOn = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b0; zReset = 1'b0;
    cyc();

    // Single entry, one-cycle latency.
    in_valid = 1'b1; in_Data = 32'h0000_00A5; in_Ctrl = 9'h1FF; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("lat1_valid", 64'(out_valid), 64'(1));
    check("lat1_data", 64'(out_Data), 64'h0000_00A5);
    check("lat1_ctrl", 64'(out_Ctrl), 64'h1FF);
    check("lat1_occ", 64'(occupancy), 64'(1));
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    cyc();

    // Fill main and skid under backpressure, then release.
    in_valid = 1'b1; in_Ctrl = 9'h003; in_Data = 32'h1;
    cyc();
    in_Data = 32'h2;
    cyc();
    in_Data = 32'h3;
    @(negedge clk);
    check("fill_hold_data", 64'(out_Data), 64'h1);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    check("fill_main", 64'(out_Data), 64'h1);
    check("fill_in_ready", 64'(in_ready), 64'(0));
    check("fill_occ", 64'(occupancy), 64'(2));
    cyc();
    @(negedge clk);
    check("drain_2", 64'(out_Data), 64'h2);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_3", 64'(out_Data), 64'h3);
    cyc();
    @(negedge clk);
    check("drain_empty", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // Flush with a full stage; the offered word must never appear.
    in_valid = 1'b1; in_Ctrl = 9'h011; in_Data = 32'h10;
    cyc();
    in_Data = 32'h11;
    cyc();
    in_Data = 32'h77; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_occ", 64'(occupancy), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ctrl", 64'(out_Ctrl), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    // Flush coinciding with an accept into an empty stage.
    in_valid = 1'b1; in_Data = 32'h78; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_accept_dropped", 64'(out_valid), 64'(0));
    repeat (2) cyc();
    out_ready = 1'b0;

    // Reset and flush together with skid full.
    in_valid = 1'b1; in_Data = 32'h20;
    cyc();
    in_Data = 32'h21;
    cyc();
    in_Data = 32'h99; reset = 1'b1; flush = 1'b1;
    cyc();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rf_occ", 64'(occupancy), 64'(0));
    check("rf_valid", 64'(out_valid), 64'(0));
    check("rf_in_ready", 64'(in_ready), 64'(1));
    check("rf_data", 64'(out_Data), 64'(0));
    check("rf_ctrl", 64'(out_Ctrl), 64'(0));
    in_valid = 1'b1; in_Data = 32'h5A; in_Ctrl = 9'h0A6;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("rf_first_valid", 64'(out_valid), 64'(1));
    check("rf_first_data", 64'(out_Data), 64'h5A);
    check("rf_first_occ", 64'(occupancy), 64'(1));
    out_ready = 1'b1;
    cyc();

    // Sustained streaming: one per cycle at occupancy 1.
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_Data = 32'h100 + 32'(i);
      cyc();
      if (i > 0) check("stream_occ", 64'(occupancy), 64'(1));
    end
    in_valid = 1'b0;
    cyc();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_Data   = $urandom;
      in_Ctrl   = 9'($urandom);
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    check("final_empty", 64'(occupancy), 64'(0));

    // No-zero build keeps the last control word through a bubble.
    zInValid = 1'b1; zInData = 32'h12; zInCtrl = 9'h155; zOutReady = 1'b1;
    cyc();
    zInValid = 1'b0;
    @(negedge clk);
    check("nz_valid", 64'(zOutValid), 64'(1));
    check("nz_ctrl_live", 64'(zOutCtrl), 64'h155);
    cyc();
    @(negedge clk);
    check("nz_drained", 64'(zOutValid), 64'(0));
    check("nz_ctrl_kept", 64'(zOutCtrl), 64'h155);
    check("nz_occ", 64'(zOcc), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
